// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared RV32I core constants and types used by reg_file, alu
//               and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd1;
    localparam reg_addr_t REG_SP   = 5'd2;

    localparam word_t SP_INIT = 32'h0000_3FFC;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : RV32I integer register file, 2 combinational read ports,
//               1 synchronous write port, committed-write counter.
//               Optional same-cycle write forwarding: define RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import cpu_pkg::*;
#(
    parameter int                        XLEN    = cpu_pkg::XLEN,
    parameter int                        NREG    = 32,
    parameter int                        AW      = cpu_pkg::REG_AW,
    parameter logic [cpu_pkg::XLEN-1:0]  SP_INIT = cpu_pkg::SP_INIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] d1,
    output logic [XLEN-1:0] d2,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wd,
    output logic [31:0]     wr_count
);

    if (AW != $clog2(NREG)) begin : g_aw_check
        $error("reg_file: AW must equal clog2(NREG)");
    end

    logic [XLEN-1:0] w_regs [NREG];
    logic            w_commit;
    logic [31:0]     r_wr_count;

    assign w_commit = we && (rd_addr != AW'(REG_ZERO));

    // x0 has no storage; it reads as constant zero
    assign w_regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        localparam logic [XLEN-1:0] c_rst_val = (i == int'(REG_SP)) ? SP_INIT : '0;
        logic [XLEN-1:0] r_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_q <= c_rst_val;
            end else if (w_commit && (rd_addr == AW'(i))) begin
                r_q <= wd;
            end
        end

        assign w_regs[i] = r_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;

`ifdef RF_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // Forward write data to a reader of the same register in the write cycle
    assign w_fwd1 = rst && w_commit && (rs1_addr == rd_addr);
    assign w_fwd2 = rst && w_commit && (rs2_addr == rd_addr);

    assign d1 = w_fwd1 ? wd : w_regs[rs1_addr];
    assign d2 = w_fwd2 ? wd : w_regs[rs2_addr];
`else
    assign d1 = w_regs[rs1_addr];
    assign d2 = w_regs[rs2_addr];
`endif

    a_wr_ctrl_known : assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({we, rd_addr}));

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] wd;
    logic [31:0] wr_count;

    int n_cmp;
    int n_err;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .d1       (d1),
        .d2       (d2),
        .we       (we),
        .rd_addr  (rd_addr),
        .wd       (wd),
        .wr_count (wr_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        we      = 1'b1;
        rd_addr = addr;
        wd      = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_regs(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        logic [31:0] exp_fwd;
        n_cmp    = 0;
        n_err    = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        we       = 1'b0;
        rd_addr  = '0;
        wd       = '0;
        rs1_addr = 5'd2;
        rs2_addr = 5'd5;

        // Reset with the clock stopped: values must appear without an edge
        #3 rst = 1'b0;
        #1;
        chk_eq("rst_sp", d1, 32'h0000_3FFC);
        chk_eq("rst_x5", d2, 32'h0);
        chk_eq("rst_cnt", wr_count, 32'h0);

        #2 rst = 1'b1;
        clk_en = 1'b1;

        wr_reg(5'd5, 32'hDEAD_BEEF);
        rd_regs(5'd5, 5'd5);
        chk_eq("wr_x5_d1", d1, 32'hDEAD_BEEF);
        chk_eq("wr_x5_d2", d2, 32'hDEAD_BEEF);
        chk_eq("cnt_1", wr_count, 32'd1);

        wr_reg(5'd6, 32'h0000_1234);
        rd_regs(5'd6, 5'd5);
        chk_eq("wr_x6", d1, 32'h0000_1234);
        chk_eq("x5_kept", d2, 32'hDEAD_BEEF);
        chk_eq("cnt_2", wr_count, 32'd2);

        wr_reg(5'd0, 32'hFFFF_FFFF);
        rd_regs(5'd0, 5'd0);
        chk_eq("x0_d1", d1, 32'h0);
        chk_eq("x0_d2", d2, 32'h0);
        chk_eq("x0_cnt", wr_count, 32'd2);

        // Read during write of x7
        wr_reg(5'd7, 32'h0000_0011);
`ifdef RF_BYPASS_EN
        exp_fwd = 32'h0000_0022;
`else
        exp_fwd = 32'h0000_0011;
`endif
        @(negedge clk);
        we       = 1'b1;
        rd_addr  = 5'd7;
        wd       = 32'h0000_0022;
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        chk_eq("rdw_d1_pre", d1, exp_fwd);
        chk_eq("rdw_d2_pre", d2, exp_fwd);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk_eq("rdw_d1_post", d1, 32'h0000_0022);
        chk_eq("rdw_cnt", wr_count, 32'd4);

        // Reset asserted in the same cycle as a write
        wr_reg(5'd10, 32'hA5A5_A5A5);
        rd_regs(5'd10, 5'd10);
        chk_eq("wr_x10", d1, 32'hA5A5_A5A5);
        chk_eq("cnt_5", wr_count, 32'd5);
        @(negedge clk);
        we      = 1'b1;
        rd_addr = 5'd11;
        wd      = 32'h0000_0077;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("mid_rst_cnt", wr_count, 32'h0);
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;
        rd_regs(5'd10, 5'd11);
        chk_eq("rst_x10", d1, 32'h0);
        chk_eq("rst_x11", d2, 32'h0);
        rd_regs(5'd2, 5'd7);
        chk_eq("rst_sp2", d1, 32'h0000_3FFC);
        chk_eq("rst_x7", d2, 32'h0);
        chk_eq("rel_cnt", wr_count, 32'h0);
        wr_reg(5'd3, 32'h0000_0003);
        chk_eq("first_cnt", wr_count, 32'd1);

        // Counter wrap via hierarchical preload
        @(negedge clk);
        dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        chk_eq("preload", wr_count, 32'hFFFF_FFFF);
        wr_reg(5'd4, 32'h0000_0004);
        chk_eq("wrap", wr_count, 32'h0);
        rd_regs(5'd4, 5'd3);
        chk_eq("wrap_x4", d1, 32'h0000_0004);
        chk_eq("wrap_x3", d2, 32'h0000_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- RV32I integer register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
- Read ports drive the ALU operand inputs `d1`/`d2`.
- Write port takes the ALU result (or other write-back data) back in, closing the operand/result loop around the ALU.
- Also keeps a retired-write counter for debug/perf visibility.

Parameters:
- XLEN, 32, data width of every register and port.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width; must equal $clog2(NREG).
- SP_INIT, 32'h0000_3FFC, reset value of x2 (sp); every other register resets to 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- d1  out  XLEN  read data 1 (ALU operand 1).
- d2  out  XLEN  read data 2 (ALU operand 2 / store data).
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- wd  in  XLEN  write data (normally `alu_output`).
- wr_count  out  32  number of committed writes since reset.

Behaviour:
- Reset:
  - rst low forces, asynchronously and regardless of clk, x1..x31 = 0 except x2 = SP_INIT.
  - It also forces wr_count = 0.
  - Holds while rst is low; writes are ignored during reset.
  - A reset asserted mid-write (same cycle as we=1) wins: the write is lost and wr_count stays 0.
- Read:
  - Purely combinational, zero-cycle latency.
  - d1 = regs[rs1_addr] and d2 = regs[rs2_addr].
  - Address 0 always returns 0.
  - Both ports may address the same register; both return the same value.
- Write:
  - On rising clk with rst high, we=1 and rd_addr != 0: regs[rd_addr] <= wd. The value is visible on reads the following cycle.
  - we=1 with rd_addr=0: no storage change and wr_count does not increment. x0 has no storage; it is tied to 0.
  - we=0: no change.
- Read-during-write (same cycle, rs == rd_addr != 0, we=1): behaviour is set by RF_BYPASS_EN (see Optional Feature).
- wr_count:
  - Increments by 1 on each committed write (we=1, rd_addr!=0, rst high).
  - 32-bit, wraps 32'hFFFF_FFFF -> 0 with no flag.
- X-handling: X on we during reset is ignored. Outside reset, X on we or rd_addr is a bench error (assertion), not defined behaviour.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding is enabled.
  - When we=1, rd_addr!=0 and rs1_addr==rd_addr, d1 = wd combinationally in the same cycle; likewise for d2/rs2_addr.
  - Forwarding is suppressed while rst is low.
- Not defined:
  - Reads return the pre-write stored value in that cycle.
  - The new value appears the cycle after the edge.
  - No forwarding mux is synthesized.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN and REG_AW constants.
  - Typedefs word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_AW-1:0]).
  - Named register indices REG_ZERO=0, REG_RA=1, REG_SP=2.
  - SP_INIT default.
- These are shared with alu and the decoder.
- No sub-module. Storage array, write logic, optional bypass mux and counter all live in reg_file; the bypass is a two-line mux, not worth its own module.

Test Plan:
- Reset values: assert rst=0 mid-cycle with clk stopped -> immediately d1(rs1=2)=32'h0000_3FFC, d2(rs2=5)=0, wr_count=0, with no clock edge needed.
- Basic write/read:
  - we=1, rd_addr=5, wd=32'hDEAD_BEEF, one edge, then rs1_addr=5 and rs2_addr=5 -> d1=d2=32'hDEAD_BEEF, wr_count=1.
  - Then write x6=32'h1234 and confirm x5 unchanged.
- x0 protection: we=1, rd_addr=0, wd=32'hFFFF_FFFF, one edge -> d1(rs1=0)=0, wr_count unchanged.
- Read-during-write: x7 holds 32'h11; drive we=1, rd_addr=7, wd=32'h22, rs1_addr=7 before the edge.
  - With RF_BYPASS_EN: d1=32'h22.
  - Without: d1=32'h11.
  - After the edge, d1=32'h22 in both builds.
- Reset mid-operation: after writing x10=32'hA5A5_A5A5 (wr_count=N), pulse rst low in the same cycle as a write to x11.
  - Required: x10=0, x11=0, x2=SP_INIT, wr_count=0 after release.
  - The first write after release increments wr_count to 1.
- Counter wrap: force wr_count to 32'hFFFF_FFFF via hierarchical preload, then one committed write -> wr_count=0.
